alu_mul_sequencer: RTL and testbench

Multi-cycle controller that computes the 32x32 product (low 32 bits) by sequencing the shared combinational ALU through shift-add iterations.
- Uses ALU ops ADD (3'b000), SLL (3'b011) and SRL (3'b100), so the ALU needs no dedicated multiply hardware.
- Sits beside the ALU in the execute stage and owns the ALU operand/opcode bus while busy.
- Start/busy/done handshake toward the issuing control logic.

---
 rtl/alu_mul_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer: drives the shared ALU through ADD/SLL/SRL steps to form the low 32 bits of op_a*op_b.
// Latency: done at T+1+2k+p with early exit (k = index of the top set bit of op_b plus 1, p = popcount), T+1 for op_b=0.
// Backpressure: none; start is taken only in IDLE, and busy stays high until the one-cycle DONE state has passed.
module alu_mul_sequencer #(
  parameter int ITER_MAX   = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SLL, S_SRL, S_DONE} state_t;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SLL    = 3'b011;
  localparam logic [2:0] OP_SRL    = 3'b100;
  localparam logic [5:0] ITER_LAST = 6'(ITER_MAX);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mc_q, mc_d;
  logic [31:0] mp_q, mp_d;
  logic [31:0] product_q, product_d;
  logic [5:0]  iter_q, iter_d;
  logic [5:0]  iter_inc;
  logic        done_q, done_d;

  // Next-state and datapath updates; ALU results are consumed only in ADD/SLL/SRL.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    iter_d    = iter_q;
    product_d = product_q;
    done_d    = 1'b0;
    iter_inc  = iter_q + 6'd1;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          acc_d  = 32'd0;
          mc_d   = op_a;
          mp_d   = op_b;
          iter_d = 6'd0;
          if (op_b == 32'd0)  state_d = S_DONE;
          else if (op_b[0])   state_d = S_ADD;
          else                state_d = S_SLL;
        end
      end
      S_ADD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = alu_result;
          state_d = S_SLL;
        end
      end
      S_SLL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mc_d    = alu_result;
          state_d = S_SRL;
        end
      end
      S_SRL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mp_d   = alu_result;
          iter_d = iter_inc;
          if ((EARLY_EXIT && alu_zero) || (iter_inc == ITER_LAST)) state_d = S_DONE;
          else if (alu_result[0])                                  state_d = S_ADD;
          else                                                     state_d = S_SLL;
        end
      end
      // Completion is already committed on entry, so abort here has nothing to cancel.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // done and product are registered on entry to DONE so the pulse lines up with the state.
    if (state_d == S_DONE) begin
      done_d    = 1'b1;
      product_d = acc_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= 32'd0;
      mc_q      <= 32'd0;
      mp_q      <= 32'd0;
      iter_q    <= 6'd0;
      product_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // The ALU operand bus is a pure decode of the current state.
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = OP_ADD;
    case (state_q)
      S_ADD: begin
        alu_a  = acc_q;
        alu_b  = mc_q;
        alu_op = OP_ADD;
      end
      S_SLL: begin
        alu_a  = mc_q;
        alu_b  = 32'd1;
        alu_op = OP_SLL;
      end
      S_SRL: begin
        alu_a  = mp_q;
        alu_b  = 32'd1;
        alu_op = OP_SRL;
      end
      default: begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = OP_ADD;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural ALU beside each instance.
// Latency: directed vectors measure start-to-done cycles against hand-computed values.
// Backpressure: exercises abort, start-while-busy, start+abort in IDLE and async reset mid-run.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;

  logic        start_x, abort_x;
  logic [31:0] op_a_x, op_b_x;
  logic        busy_x, done_x;
  logic [31:0] product_x, alu_a_x, alu_b_x, alu_result_x;
  logic [2:0]  alu_op_x;
  logic        alu_zero_x;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ops [0:127];
  int         n_ops;
  int         busy_gaps;
  logic       post_done, post_busy;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b011:  return a << b[4:0];
      3'b100:  return a >> b[4:0];
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  always_comb begin
    alu_result   = alu_f(alu_a, alu_b, alu_op);
    alu_zero     = (alu_result == 32'd0);
    alu_result_x = alu_f(alu_a_x, alu_b_x, alu_op_x);
    alu_zero_x   = (alu_result_x == 32'd0);
  end

  alu_mul_sequencer #(.ITER_MAX(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_mul_sequencer #(.ITER_MAX(32), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort_x), .op_a(op_a_x), .op_b(op_b_x),
    .busy(busy_x), .done(done_x), .product(product_x), .alu_a(alu_a_x), .alu_b(alu_b_x),
    .alu_op(alu_op_x), .alu_result(alu_result_x), .alu_zero(alu_zero_x)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a cycle budget; lat keeps counting from the given start value.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Issues one multiply from the current cycle T and follows it through to IDLE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int lat, output logic [31:0] prod);
    start = 1'b1; op_a = a; op_b = b;
    n_ops = 0; busy_gaps = 0;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!done && lat < 200) begin
      if (!busy) busy_gaps++;
      if (n_ops < 128) begin
        ops[n_ops] = alu_op;
        n_ops++;
      end
      tick();
      lat++;
    end
    if (!busy) busy_gaps++;
    prod = product;
    tick();
    post_done = done;
    post_busy = busy;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_prod;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs [0:8];
    int          lat;
    int          srl_cnt;
    int          pulses;
    logic [31:0] prod;
    logic [2:0]  seq2 [0:5];
    logic [2:0]  seq3 [0:4];

    vecs[0] = '{32'd5,        32'd3,        32'd15,         7};
    vecs[1] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   6};
    vecs[2] = '{32'h1234,     32'd0,        32'd0,          1};
    vecs[3] = '{32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF,  97};
    vecs[4] = '{32'd7,        32'd9,        32'd63,        11};
    vecs[5] = '{32'h10000,    32'h10000,    32'd0,         36};
    vecs[6] = '{32'h12345678, 32'd1,        32'h12345678,   4};
    vecs[7] = '{32'd3,        32'h80000000, 32'h80000000,  66};
    vecs[8] = '{32'hFFFF,     32'hFFFF,     32'hFFFE0001,  49};

    seq2[0] = 3'b000; seq2[1] = 3'b011; seq2[2] = 3'b100;
    seq2[3] = 3'b000; seq2[4] = 3'b011; seq2[5] = 3'b100;
    seq3[0] = 3'b011; seq3[1] = 3'b100; seq3[2] = 3'b000;
    seq3[3] = 3'b011; seq3[4] = 3'b100;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
    start_x = 1'b0; abort_x = 1'b0; op_a_x = '0; op_b_x = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    check("reset alu_op", alu_op, 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_b", alu_b, 0);
    rst_n = 1'b1;
    tick();

    // 5*3: ALU op ordering and latency.
    run_mul(32'd5, 32'd3, lat, prod);
    check("5x3 product", prod, 32'd15);
    check("5x3 latency", lat, 7);
    check("5x3 op count", n_ops, 6);
    for (int i = 0; i < 6; i++) check($sformatf("5x3 op[%0d]", i), ops[i], seq2[i]);

    // 0xFFFFFFFF*2: even multiplier starts with SLL, product wraps.
    run_mul(32'hFFFFFFFF, 32'd2, lat, prod);
    check("wrap op count", n_ops, 5);
    for (int i = 0; i < 5; i++) check($sformatf("wrap op[%0d]", i), ops[i], seq3[i]);

    // Async reset in cycle T+3 of 7*9 (product is 0xFFFFFFFE before).
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst product", product, 0);
    check("midrst alu_op", alu_op, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      run_mul(vecs[v].a, vecs[v].b, lat, prod);
      check($sformatf("vec%0d product", v), prod, vecs[v].exp_prod);
      check($sformatf("vec%0d latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d busy gaps", v), busy_gaps, 0);
      check($sformatf("vec%0d done after", v), post_done, 0);
      check($sformatf("vec%0d busy after", v), post_busy, 0);
    end

    // Abort during SLL at T+2 of 6*7, with product 15 beforehand.
    run_mul(32'd5, 32'd3, lat, prod);
    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy T+3", busy, 0);
    check("abort done T+3", done, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort done pulses", pulses, 0);
    check("abort product held", product, 32'd15);

    // Start pulse while busy must not restart or replace operands.
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_a = 32'd100; op_b = 32'd100;
    tick();
    start = 1'b0;
    wait_done(3, lat);
    check("busy-start latency", lat, 11);
    check("busy-start product", product, 32'd63);
    tick();

    // start together with abort in IDLE is not accepted.
    start = 1'b1; abort = 1'b1; op_a = 32'd2; op_b = 32'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", busy, 0);
    tick();
    check("start+abort done", done, 0);
    check("start+abort product", product, 32'd63);

    // Abort in DONE is ignored: 2*1 completes at T+4.
    start = 1'b1; op_a = 32'd2; op_b = 32'd1;
    tick();
    start = 1'b0;
    wait_done(1, lat);
    check("done-abort latency", lat, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done-abort product", product, 32'd2);
    check("done-abort busy", busy, 0);

    // EARLY_EXIT=0 instance always runs all 32 iterations.
    start_x = 1'b1; op_a_x = 32'd3; op_b_x = 32'd1;
    tick();
    start_x = 1'b0; op_a_x = $urandom; op_b_x = $urandom;
    lat = 1; srl_cnt = 0;
    while (!done_x && lat < 200) begin
      if (alu_op_x == 3'b100) srl_cnt++;
      tick();
      lat++;
    end
    check("full latency", lat, 66);
    check("full srl count", srl_cnt, 32);
    check("full product", product_x, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
